ngx_http_parse_time_mul_sched: RTL and testbench

- Time-shares one unsigned 16x14->30 multiplier core between NUM_REQ requesters in the ngx_http_parse_time datapath (year/day/second scaling terms).
- Round-robin arbitration, valid/ready handshake per requester, 2-stage pipeline (operand register, product register).
- Returns each result on a shared response bus with requester ID and backpressure.

---
 rtl/ngx_http_parse_time_mul_pkg.sv | 22 ++
 rtl/ngx_http_parse_time_mul_core.sv | 15 +
 rtl/ngx_http_parse_time_mul_rr_arb.sv | 35 +++
 rtl/ngx_http_parse_time_mul_sched.sv | 131 +++++++++++++
 tb/tb_ngx_http_parse_time_mul_sched.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ngx_http_parse_time_mul_pkg.sv
// rtl/ngx_http_parse_time_mul_pkg.sv - shared constants and types for the parse_time multiplier scheduler
package ngx_http_parse_time_mul_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_WIDTH = 16;
  localparam int DEF_B_WIDTH = 14;
  localparam int DEF_P_WIDTH = DEF_A_WIDTH + DEF_B_WIDTH;

  // Ceiling log2, never below 1 so an id always has at least one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef logic [DEF_A_WIDTH-1:0]          opa_t;
  typedef logic [DEF_B_WIDTH-1:0]          opb_t;
  typedef logic [DEF_P_WIDTH-1:0]          prod_t;
  typedef logic [clog2(DEF_NUM_REQ)-1:0]   rid_t;

endpackage

// File: rtl/ngx_http_parse_time_mul_core.sv
// rtl/ngx_http_parse_time_mul_core.sv - unsigned A x B multiplier core shared by all requesters
module ngx_http_parse_time_mul_core #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 14,
  parameter int P_WIDTH = 30
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  // Both operands widened to the full product width so nothing is truncated
  assign p = P_WIDTH'(a) * P_WIDTH'(b);

endmodule

// File: rtl/ngx_http_parse_time_mul_rr_arb.sv
// rtl/ngx_http_parse_time_mul_rr_arb.sv - combinational round-robin grant for the multiplier scheduler
module ngx_http_parse_time_mul_rr_arb
  import ngx_http_parse_time_mul_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  input  logic                enable,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic found;

  // Walk k steps from rr_ptr (wrapping) and grant the first valid requester hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && req_valid[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = ID_WIDTH'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/ngx_http_parse_time_mul_sched.sv
// rtl/ngx_http_parse_time_mul_sched.sv - round-robin time-sharing of one multiplier across requesters
module ngx_http_parse_time_mul_sched
  import ngx_http_parse_time_mul_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int A_WIDTH  = DEF_A_WIDTH,
  parameter int B_WIDTH  = DEF_B_WIDTH,
  parameter int P_WIDTH  = DEF_P_WIDTH,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       busy
);

  generate
    if (P_WIDTH != A_WIDTH + B_WIDTH) begin : g_bad_pwidth
      $error("P_WIDTH must equal A_WIDTH + B_WIDTH");
    end
    if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_idwidth
      $error("ID_WIDTH too narrow for NUM_REQ");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_numreq
      $error("NUM_REQ must be in 2..8");
    end
  endgenerate

  logic                s1_valid;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;
  logic [ID_WIDTH-1:0] s1_id;
  logic                s2_valid;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic                adv1, adv2;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] ptr_next;
  logic                accept;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;
  logic [P_WIDTH-1:0]  core_p;

  // Stage 2 moves when empty or draining; stage 1 moves when empty or stage 2 moves
  assign adv2 = !s2_valid | rsp_ready;
  assign adv1 = !s1_valid | adv2;

  // Reset gating keeps req_ready low while ap_rst_n is asserted
  ngx_http_parse_time_mul_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (adv1 & ap_rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign ptr_next  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);

  // One-hot operand mux selecting the granted requester's slices
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  ngx_http_parse_time_mul_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_core (
    .a (s1_a),
    .b (s1_b),
    .p (core_p)
  );

  // Stage 1: capture granted operands and step the round-robin pointer past the winner
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (adv1) begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_id    <= grant_idx;
        rr_ptr   <= ptr_next;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: register the product and owner id; holds while the consumer stalls
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      rsp_p    <= '0;
      rsp_id   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      rsp_p    <= core_p;
      rsp_id   <= s1_id;
    end
  end

  assign rsp_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_ngx_http_parse_time_mul_sched.sv
// tb/tb_ngx_http_parse_time_mul_sched.sv - randomized scoreboard bench for the shared multiplier scheduler
module tb_ngx_http_parse_time_mul_sched;
  import ngx_http_parse_time_mul_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 14;
  localparam int PW = 30;
  localparam int IW = 2;

  logic            ap_clk    = 1'b0;
  logic            ap_rst_n  = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a     = '0;
  logic [N*BW-1:0] req_b     = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [PW-1:0]   rsp_p;
  logic            busy;

  ngx_http_parse_time_mul_sched dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-requester job queues {a,b}; the front job is what the requester presents
  logic [AW+BW-1:0] jobq [N][$];
  logic [N-1:0]     hs = '0;

  // Requester driver: drop the accepted job, present the next one
  always @(posedge ap_clk) begin : drv
    logic [AW+BW-1:0] j;
    #2;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && jobq[i].size() > 0) void'(jobq[i].pop_front());
      if (jobq[i].size() > 0) begin
        j = jobq[i][0];
        req_valid[i]       = 1'b1;
        req_a[i*AW +: AW]  = j[AW+BW-1:BW];
        req_b[i*BW +: BW]  = j[BW-1:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Reference: ordered list of in-flight results, each aged by clock edges since acceptance
  typedef struct {
    int          id;
    logic [63:0] p;
    int          age;
  } ent_t;

  ent_t        mq[$];
  int          mptr   = 0;
  int          n_xfer = 0;
  int          n_acc  = 0;
  logic [PW-1:0] last_p [N];

  always @(negedge ap_clk) begin : cmp
    logic        ev;
    logic [N-1:0] eg;
    int          gi;
    int          c;
    ent_t        e;
    if (!ap_rst_n) begin
      mq.delete();
      mptr = 0;
      hs   = '0;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_rsp_p",     64'(rsp_p),     64'(0));
      chk("rst_rsp_id",    64'(rsp_id),    64'(0));
    end else begin
      ev = (mq.size() > 0) && (mq[0].age >= 2);
      gi = -1;
      if (mq.size() < 2 || rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          c = (mptr + k) % N;
          if (gi < 0 && req_valid[c]) gi = c;
        end
      end
      eg = '0;
      if (gi >= 0) eg[gi] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(eg));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("busy",      64'(busy),      64'(mq.size() > 0));
      if (ev) begin
        chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
        chk("rsp_p",  64'(rsp_p),  mq[0].p);
      end
      hs = req_valid & req_ready;
      n_acc += $countones(hs);
      if (rsp_valid && rsp_ready) begin
        n_xfer++;
        last_p[rsp_id] = rsp_p;
      end
      if (ev && rsp_ready) void'(mq.pop_front());
      foreach (mq[k]) mq[k].age++;
      if (gi >= 0) begin
        e.id  = gi;
        e.p   = 64'(req_a[gi*AW +: AW]) * 64'(req_b[gi*BW +: BW]);
        e.age = 1;
        mq.push_back(e);
        mptr = (gi + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [AW+BW-1:0] rand_job();
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    int sa, sb;
    sa = $urandom_range(7);
    sb = $urandom_range(7);
    a = (sa == 0) ? '0 : (sa == 1) ? '1 : AW'($urandom);
    b = (sb == 0) ? '0 : (sb == 1) ? '1 : BW'($urandom);
    return {a, b};
  endfunction

  task automatic wait_idle(input string name);
    int n;
    int pend;
    rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      pend = 0;
      for (int i = 0; i < N; i++) pend += jobq[i].size();
      n++;
    end while ((pend != 0 || busy) && n < 300);
    chk(name, 64'(pend != 0 || busy), 64'(0));
  endtask

  task automatic do_reset();
    tick();
    ap_rst_n = 1'b0;
    for (int i = 0; i < N; i++) jobq[i].delete();
    tick();
    tick();
    ap_rst_n = 1'b1;
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int x0, a0;
    logic [AW+BW-1:0] j3;

    // Reset state
    repeat (3) @(negedge ap_clk);
    chk("reset_busy",  64'(busy),      64'(0));
    chk("reset_rsp_p", 64'(rsp_p),     64'(0));
    tick();
    ap_rst_n = 1'b1;

    // Single request 3*5 from requester 0
    rsp_ready = 1'b1;
    jobq[0].push_back({16'd3, 14'd5});
    @(negedge ap_clk);
    chk("b_ready0", 64'(req_ready), 64'(4'b0001));
    @(negedge ap_clk);
    chk("b_not_yet", 64'(rsp_valid), 64'(0));
    @(negedge ap_clk);
    chk("b_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("b_rsp_p",     64'(rsp_p),     64'(15));
    chk("b_rsp_id",    64'(rsp_id),    64'(0));
    @(negedge ap_clk);
    chk("b_busy_idle", 64'(busy), 64'(0));

    // All requesters valid: grants rotate 0,1,2,3,0,1
    do_reset();
    x0 = n_xfer;
    for (int i = 0; i < N; i++) repeat (3) jobq[i].push_back(rand_job());
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      chk("c_grant_order", 64'(oh2i(req_ready)), 64'(i % 4));
    end
    tick();
    wait_idle("c_idle");
    chk("c_xfers", 64'(n_xfer - x0), 64'(12));

    // Backpressure: exactly two accepts fill the pipe, then everything drains in order
    tick();
    x0 = n_xfer;
    a0 = n_acc;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) repeat (2) jobq[i].push_back(rand_job());
    repeat (8) @(negedge ap_clk);
    chk("d_accepts",    64'(n_acc - a0), 64'(2));
    chk("d_ready_zero", 64'(req_ready),  64'(0));
    chk("d_rsp_hold",   64'(rsp_valid),  64'(1));
    tick();
    wait_idle("d_idle");
    chk("d_xfers", 64'(n_xfer - x0), 64'(8));

    // Operand extremes
    tick();
    last_p[1] = '1;
    last_p[2] = '0;
    jobq[2].push_back({16'hffff, 14'h3fff});
    jobq[1].push_back({16'h0000, 14'h3fff});
    tick();
    wait_idle("e_idle");
    chk("e_max_product",  64'(last_p[2]), 64'(1073659905));
    chk("e_zero_product", 64'(last_p[1]), 64'(0));

    // Reset with both stages occupied
    tick();
    rsp_ready = 1'b0;
    repeat (2) jobq[0].push_back(rand_job());
    jobq[1].push_back(rand_job());
    repeat (3) @(negedge ap_clk);
    chk("f_busy_full", 64'(busy),      64'(1));
    chk("f_rsp_full",  64'(rsp_valid), 64'(1));
    tick();
    ap_rst_n = 1'b0;
    for (int i = 0; i < N; i++) jobq[i].delete();
    #1;
    chk("f_async_valid", 64'(rsp_valid), 64'(0));
    chk("f_async_busy",  64'(busy),      64'(0));
    chk("f_async_p",     64'(rsp_p),     64'(0));
    chk("f_async_ready", 64'(req_ready), 64'(0));
    tick();
    tick();
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    x0 = n_xfer;
    repeat (4) @(negedge ap_clk);
    chk("f_no_stale", 64'(n_xfer - x0), 64'(0));
    tick();
    j3 = rand_job();
    jobq[3].push_back(j3);
    @(negedge ap_clk);
    chk("f_req3_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    wait_idle("f_idle");
    chk("f_req3_xfers",  64'(n_xfer - x0), 64'(1));
    chk("f_req3_product", 64'(last_p[3]), 64'(j3[AW+BW-1:BW]) * 64'(j3[BW-1:0]));

    // Lone requester 1, then requester 0 joins and they alternate
    tick();
    repeat (5) jobq[1].push_back(rand_job());
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("g_solo_grant", 64'(oh2i(req_ready)), 64'(1));
    end
    tick();
    repeat (4) jobq[0].push_back(rand_job());
    repeat (4) jobq[1].push_back(rand_job());
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk("g_alt_grant", 64'(oh2i(req_ready)), 64'(i % 2));
    end
    tick();
    wait_idle("g_idle");

    // Random traffic with random backpressure
    repeat (1500) begin
      tick();
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++)
        if (jobq[i].size() < 2 && $urandom_range(9) < 3) jobq[i].push_back(rand_job());
    end
    tick();
    wait_idle("h_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
